branch_predictor_btb: RTL and testbench

- Dynamic branch predictor for the RV32I pipeline: a direct-mapped BTB with one 2-bit saturating counter per entry.
- Predicts direction and target at fetch.
- Trains on the resolved outcome from EX and requests a flush/redirect on a mispredict.
- Emits one-cycle registered per-branch event strobes (o_is_br, o_is_correct) that feed the branch-prediction statistics scoreboard directly downstream.

---
 rtl/branch_predictor_btb_if.sv | 30 +++
 rtl/branch_predictor_btb.sv | 102 ++++++++++
 tb/tb_branch_predictor_btb.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_btb_if.sv
// Fetch-lookup, EX-resolve and event-strobe signals between the pipeline and the branch predictor.
// master = pipeline side (drives fetch/resolve inputs), slave = predictor.
interface branch_predictor_btb_if;
  logic [31:0] i_fetch_pc;
  logic        o_pred_taken;
  logic [31:0] o_pred_target;
  logic        i_ex_valid;
  logic        i_ex_is_br;
  logic [31:0] i_ex_pc;
  logic        i_ex_taken;
  logic [31:0] i_ex_target;
  logic        i_ex_pred_taken;
  logic [31:0] i_ex_pred_target;
  logic        o_flush;
  logic [31:0] o_redirect_pc;
  logic        o_is_br;
  logic        o_is_correct;

  modport master (
    output i_fetch_pc, i_ex_valid, i_ex_is_br, i_ex_pc, i_ex_taken, i_ex_target,
           i_ex_pred_taken, i_ex_pred_target,
    input  o_pred_taken, o_pred_target, o_flush, o_redirect_pc, o_is_br, o_is_correct
  );

  modport slave (
    input  i_fetch_pc, i_ex_valid, i_ex_is_br, i_ex_pc, i_ex_taken, i_ex_target,
           i_ex_pred_taken, i_ex_pred_target,
    output o_pred_taken, o_pred_target, o_flush, o_redirect_pc, o_is_br, o_is_correct
  );
endinterface

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with 2-bit counters: combinational lookup and flush, table update and event strobes 1 cycle later.
// No backpressure: one lookup and one training update accepted every cycle.
module branch_predictor_btb #(
  parameter int INDEX_W = 4,
  parameter int TAG_W   = 30 - INDEX_W
) (
  input logic                  i_clk,
  input logic                  i_rst,
  branch_predictor_btb_if.slave bp
);

  localparam int ENTRIES = 1 << INDEX_W;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic [1:0]       ctr;
  } entry_t;

  entry_t btb_q [ENTRIES];
  logic   is_br_q;
  logic   is_correct_q;

  // Fetch-side lookup
  logic [INDEX_W-1:0] fetch_idx;
  logic [TAG_W-1:0]   fetch_tag;
  entry_t             fetch_ent;
  logic               fetch_hit;
  logic [31:0]        fetch_pc_inc;

  assign fetch_idx    = bp.i_fetch_pc[INDEX_W+1:2];
  assign fetch_tag    = bp.i_fetch_pc[31:INDEX_W+2];
  assign fetch_ent    = btb_q[fetch_idx];
  assign fetch_hit    = fetch_ent.valid && (fetch_ent.tag == fetch_tag);
  assign fetch_pc_inc = bp.i_fetch_pc + 32'd4;

  assign bp.o_pred_taken  = fetch_hit & fetch_ent.ctr[1];
  assign bp.o_pred_target = (fetch_hit & fetch_ent.ctr[1]) ? fetch_ent.target : fetch_pc_inc;

  // EX-side resolve
  logic [INDEX_W-1:0] ex_idx;
  logic [TAG_W-1:0]   ex_tag;
  entry_t             ex_ent;
  logic               ex_hit;
  logic [31:0]        ex_pc_inc;
  logic               br;
  logic               correct;
  logic               nonbr_alias;
  logic [1:0]         ctr_next;

  assign ex_idx    = bp.i_ex_pc[INDEX_W+1:2];
  assign ex_tag    = bp.i_ex_pc[31:INDEX_W+2];
  assign ex_ent    = btb_q[ex_idx];
  assign ex_hit    = ex_ent.valid && (ex_ent.tag == ex_tag);
  assign ex_pc_inc = bp.i_ex_pc + 32'd4;

  assign br          = bp.i_ex_valid & bp.i_ex_is_br;
  assign correct     = (bp.i_ex_pred_taken == bp.i_ex_taken) &
                       (~bp.i_ex_taken | (bp.i_ex_pred_target == bp.i_ex_target));
  // A non-branch that was predicted taken means the BTB entry aliased onto it.
  assign nonbr_alias = bp.i_ex_valid & ~bp.i_ex_is_br & bp.i_ex_pred_taken;

  assign bp.o_flush       = (br & ~correct) | nonbr_alias;
  assign bp.o_redirect_pc = (br & bp.i_ex_taken) ? bp.i_ex_target : ex_pc_inc;

  always_comb begin
    ctr_next = ex_ent.ctr;
    if (bp.i_ex_taken) begin
      if (ex_ent.ctr != 2'b11) ctr_next = ex_ent.ctr + 2'd1;
    end else begin
      if (ex_ent.ctr != 2'b00) ctr_next = ex_ent.ctr - 2'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: 2'b01};
      end
      is_br_q      <= 1'b0;
      is_correct_q <= 1'b0;
    end else begin
      is_br_q      <= br;
      is_correct_q <= br & correct;
      if (br) begin
        if (ex_hit) begin
          btb_q[ex_idx].ctr <= ctr_next;
          if (bp.i_ex_taken) btb_q[ex_idx].target <= bp.i_ex_target;
        end else if (bp.i_ex_taken) begin
          btb_q[ex_idx] <= '{valid: 1'b1, tag: ex_tag, target: bp.i_ex_target, ctr: 2'b10};
        end
      end else if (nonbr_alias && ex_hit) begin
        btb_q[ex_idx].valid <= 1'b0;
      end
    end
  end

  assign bp.o_is_br      = is_br_q;
  assign bp.o_is_correct = is_correct_q;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Self-checking bench: directed test-plan sequences, then randomized traffic against a table-level reference model.
module tb_branch_predictor_btb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_predictor_btb_if bif ();

  branch_predictor_btb #(.INDEX_W(4), .TAG_W(26)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bp    (bif.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: 16 entries indexed by (pc/4) mod 16, tag is pc/64.
  bit          m_valid [16];
  int unsigned m_tag   [16];
  bit [31:0]   m_tgt   [16];
  int          m_ctr   [16];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int m_idx(input bit [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic bit m_hit(input bit [31:0] pc);
    return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == pc / 64);
  endfunction

  function automatic bit m_pred_taken(input bit [31:0] pc);
    return m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
  endfunction

  function automatic bit [31:0] m_pred_target(input bit [31:0] pc);
    bit [31:0] nxt;
    nxt = pc + 32'd4;
    return m_pred_taken(pc) ? m_tgt[m_idx(pc)] : nxt;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0;
      m_ctr[i]   = 1;
    end
  endtask

  task automatic m_update();
    int  i;
    bit  br;
    br = bif.i_ex_valid && bif.i_ex_is_br;
    i  = m_idx(bif.i_ex_pc);
    if (rst) m_reset();
    else if (br) begin
      if (m_hit(bif.i_ex_pc)) begin
        m_ctr[i] = bif.i_ex_taken ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                                  : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
        if (bif.i_ex_taken) m_tgt[i] = bif.i_ex_target;
      end else if (bif.i_ex_taken) begin
        m_valid[i] = 1;
        m_tag[i]   = bif.i_ex_pc / 64;
        m_tgt[i]   = bif.i_ex_target;
        m_ctr[i]   = 2;
      end
    end else if (bif.i_ex_valid && bif.i_ex_pred_taken && m_hit(bif.i_ex_pc)) begin
      m_valid[i] = 0;
    end
  endtask

  task automatic drive_ex(input bit v, input bit isbr, input bit [31:0] pc, input bit t,
                          input bit [31:0] tg, input bit pt, input bit [31:0] ptg);
    bif.i_ex_valid       = v;
    bif.i_ex_is_br       = isbr;
    bif.i_ex_pc          = pc;
    bif.i_ex_taken       = t;
    bif.i_ex_target      = tg;
    bif.i_ex_pred_taken  = pt;
    bif.i_ex_pred_target = ptg;
  endtask

  task automatic idle_ex();
    drive_ex(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
  endtask

  // One clock: check combinational outputs mid-cycle, advance, check strobes after the edge.
  task automatic step();
    bit        br, cor, fl, e_br, e_cor;
    bit [31:0] redir, nxt;
    @(negedge clk);
    chk("pred_taken", {31'b0, bif.o_pred_taken}, {31'b0, m_pred_taken(bif.i_fetch_pc)});
    chk("pred_target", bif.o_pred_target, m_pred_target(bif.i_fetch_pc));
    br    = bif.i_ex_valid && bif.i_ex_is_br;
    cor   = (bif.i_ex_pred_taken == bif.i_ex_taken) &&
            (!bif.i_ex_taken || bif.i_ex_pred_target == bif.i_ex_target);
    fl    = (br && !cor) || (bif.i_ex_valid && !bif.i_ex_is_br && bif.i_ex_pred_taken);
    nxt   = bif.i_ex_pc + 32'd4;
    redir = bif.i_ex_taken ? bif.i_ex_target : nxt;
    chk("flush", {31'b0, bif.o_flush}, {31'b0, fl});
    if (fl) chk("redirect", bif.o_redirect_pc, redir);
    e_br  = !rst && br;
    e_cor = !rst && br && cor;
    @(posedge clk);
    m_update();
    #1;
    chk("is_br", {31'b0, bif.o_is_br}, {31'b0, e_br});
    chk("is_correct", {31'b0, bif.o_is_correct}, {31'b0, e_cor});
  endtask

  task automatic expect_fetch(input string tag, input bit [31:0] pc, input bit t, input bit [31:0] tg);
    bif.i_fetch_pc = pc;
    #2;
    chk({tag, "_taken"}, {31'b0, bif.o_pred_taken}, {31'b0, t});
    chk({tag, "_target"}, bif.o_pred_target, tg);
  endtask

  bit [31:0] pool [8] = '{32'h100, 32'h140, 32'h180, 32'h1C0, 32'h104, 32'h144, 32'hFFFF_FFFC, 32'h3C};
  bit [31:0] tpool [4] = '{32'h200, 32'h300, 32'h400, 32'h0};

  initial begin
    rst = 1'b1;
    bif.i_fetch_pc = 32'h0;
    idle_ex();
    @(posedge clk);
    @(posedge clk);
    m_reset();
    #1;
    chk("rst_is_br", {31'b0, bif.o_is_br}, 32'd0);
    chk("rst_is_correct", {31'b0, bif.o_is_correct}, 32'd0);
    rst = 1'b0;

    // Cold lookup, idle strobes
    expect_fetch("cold", 32'h100, 0, 32'h104);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("idle_is_br", {31'b0, bif.o_is_br}, 32'd0);
    end

    // First taken resolve mispredicted, allocates with ctr=10
    drive_ex(1, 1, 32'h100, 1, 32'h200, 0, 32'h104);
    #2;
    chk("alloc_flush", {31'b0, bif.o_flush}, 32'd1);
    chk("alloc_redirect", bif.o_redirect_pc, 32'h200);
    step();
    chk("alloc_is_br", {31'b0, bif.o_is_br}, 32'd1);
    chk("alloc_is_correct", {31'b0, bif.o_is_correct}, 32'd0);
    idle_ex();
    expect_fetch("alloc_pred", 32'h100, 1, 32'h200);
    step();

    // Three correct taken resolves saturate, then one NT
    for (int k = 0; k < 3; k++) begin
      drive_ex(1, 1, 32'h100, 1, 32'h200, 1, 32'h200);
      step();
      chk("sat_is_correct", {31'b0, bif.o_is_correct}, 32'd1);
    end
    drive_ex(1, 1, 32'h100, 0, 32'h200, 1, 32'h200);
    #2;
    chk("nt_flush", {31'b0, bif.o_flush}, 32'd1);
    chk("nt_redirect", bif.o_redirect_pc, 32'h104);
    step();
    idle_ex();
    expect_fetch("after_nt", 32'h100, 1, 32'h200);
    step();

    // Aliasing at the same index
    expect_fetch("alias_miss", 32'h140, 0, 32'h144);
    drive_ex(1, 1, 32'h140, 1, 32'h300, 0, 32'h144);
    step();
    idle_ex();
    expect_fetch("alias_old", 32'h100, 0, 32'h104);
    step();
    expect_fetch("alias_new", 32'h140, 1, 32'h300);
    step();

    // Non-branch predicted taken invalidates the entry
    drive_ex(1, 0, 32'h140, 0, 32'h0, 1, 32'h300);
    #2;
    chk("nb_flush", {31'b0, bif.o_flush}, 32'd1);
    chk("nb_redirect", bif.o_redirect_pc, 32'h144);
    step();
    chk("nb_is_br", {31'b0, bif.o_is_br}, 32'd0);
    idle_ex();
    expect_fetch("nb_inval", 32'h140, 0, 32'h144);
    step();

    // Reset drops a simultaneous allocating update and clears the table
    drive_ex(1, 1, 32'h0C0, 1, 32'h600, 0, 32'h0C4);
    step();
    drive_ex(1, 1, 32'h180, 1, 32'h400, 0, 32'h184);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_is_br", {31'b0, bif.o_is_br}, 32'd0);
    idle_ex();
    expect_fetch("rst_mid_noalloc", 32'h180, 0, 32'h184);
    step();
    expect_fetch("rst_mid_cleared", 32'h0C0, 0, 32'h0C4);
    step();

    // Same-cycle lookup and update of one index returns old contents
    bif.i_fetch_pc = 32'h180;
    drive_ex(1, 1, 32'h180, 1, 32'h500, 0, 32'h184);
    #2;
    chk("rw_old_taken", {31'b0, bif.o_pred_taken}, 32'd0);
    chk("rw_old_target", bif.o_pred_target, 32'h184);
    step();
    idle_ex();
    expect_fetch("rw_new", 32'h180, 1, 32'h500);
    step();

    // PC+4 wraps modulo 2^32
    expect_fetch("wrap", 32'hFFFF_FFFC, 0, 32'h0);
    step();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bit [31:0] epc, tg, ptg;
      bit        isbr, t, pt;
      rst            = ($urandom_range(0, 199) == 0);
      bif.i_fetch_pc = pool[$urandom_range(0, 7)];
      epc            = pool[$urandom_range(0, 7)];
      isbr           = ($urandom_range(0, 4) != 0);
      t              = isbr ? 1'($urandom_range(0, 1)) : 1'b0;
      tg             = ($urandom_range(0, 3) == 0) ? ($urandom() & 32'hFFFF_FFFC) : tpool[$urandom_range(0, 3)];
      if ($urandom_range(0, 2) != 0) begin
        pt  = m_pred_taken(epc);
        ptg = m_pred_target(epc);
      end else begin
        pt  = 1'($urandom_range(0, 1));
        ptg = tpool[$urandom_range(0, 3)];
      end
      drive_ex(1'($urandom_range(0, 5) != 0), isbr, epc, t, tg, pt, ptg);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
